// File: rtl/interface_response_router.sv
// Return-path router: remembers which requester won each accepted request
// and steers the in-order slave responses back to that requester.
module interface_response_router #(
    parameter int OUT_COUNT       = 2,
    parameter int SEL_W           = ($clog2(OUT_COUNT) < 1) ? 1 : $clog2(OUT_COUNT),
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_W          = 32,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req_fire_i,
    input  logic [SEL_W-1:0]     req_sel_i,
    output logic                 stall_o,
    output logic [CNT_W-1:0]     outstanding_o,
    input  logic                 rsp_valid_i,
    input  logic [DATA_W-1:0]    rsp_data_i,
    output logic                 rsp_ready_o,
    output logic [OUT_COUNT-1:0] rsp_valid_o,
    output logic [DATA_W-1:0]    rsp_data_o,
    input  logic [OUT_COUNT-1:0] rsp_ready_i,
    output logic                 err_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);

    logic [SEL_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [SEL_W-1:0] fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic             full, empty, head_ok, pop, push;
    logic [SEL_W-1:0] head;

    assign full    = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty   = (count_q == '0);
    assign head    = fifo_q[rd_ptr_q];
    assign head_ok = ({1'b0, head} < (SEL_W + 1)'(OUT_COUNT));

    // Routing is purely combinational; ready is held low while in reset.
    always_comb begin
        rsp_valid_o = '0;
        rsp_ready_o = 1'b0;
        if (reset_i) begin
            rsp_ready_o = 1'b0;
        end else if (empty) begin
            rsp_ready_o = rsp_valid_i;
        end else if (!head_ok) begin
            rsp_ready_o = 1'b1;
        end else begin
            for (int i = 0; i < OUT_COUNT; i++) begin
                if (head == i[SEL_W-1:0]) begin
                    rsp_valid_o[i] = rsp_valid_i;
                    rsp_ready_o    = rsp_ready_i[i];
                end
            end
        end
    end

    assign pop           = rsp_valid_i & rsp_ready_o & ~empty;
    assign push          = req_fire_i & (~full | pop);
    assign stall_o       = full & ~pop;
    assign outstanding_o = count_q;
    assign rsp_data_o    = rsp_data_i;
    assign err_o         = err_q;

    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = req_sel_i;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        err_d    = err_q
                 | (req_fire_i & full & ~pop)
                 | (rsp_valid_i & empty)
                 | (rsp_valid_i & ~empty & ~head_ok);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_interface_response_router.sv
// Bench for interface_response_router: literal vector table plus a
// queue scoreboard that predicts routing and counters every cycle.
module tb_interface_response_router;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_fire_i = 1'b0;
    logic [0:0]  req_sel_i = '0;
    logic        stall_o;
    logic [2:0]  outstanding_o;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_data_i = '0;
    logic        rsp_ready_o;
    logic [1:0]  rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_ready_i = '0;
    logic        err_o;

    interface_response_router dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_fire_i(req_fire_i), .req_sel_i(req_sel_i),
        .stall_o(stall_o), .outstanding_o(outstanding_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
        .rsp_ready_o(rsp_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int ncmp = 0;
    int nfail = 0;
    logic [0:0] exp_q[$];
    bit err_m = 1'b0;

    typedef struct {
        logic        f;
        logic [0:0]  s;
        logic        rv;
        logic [31:0] rd;
        logic [1:0]  rr;
        logic        e_stall;
        logic [2:0]  e_out;
        logic [1:0]  e_vo;
        logic        e_ro;
        logic        e_err;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Drive one cycle at negedge, then compare against the scoreboard model.
    task automatic step(input logic f, input logic [0:0] s, input logic rv,
                        input logic [31:0] rd, input logic [1:0] rr);
        int sz;
        bit full, empty, popm, pushm, rexp;
        logic [1:0] vexp;
        @(negedge clk_i);
        req_fire_i = f; req_sel_i = s;
        rsp_valid_i = rv; rsp_data_i = rd; rsp_ready_i = rr;
        #1;
        sz = exp_q.size();
        full = (sz == 4);
        empty = (sz == 0);
        vexp = 2'b00;
        rexp = rv;
        if (!empty) begin
            vexp = rv ? (2'b01 << exp_q[0]) : 2'b00;
            rexp = rr[exp_q[0]];
        end
        popm = rv & rexp & !empty;
        pushm = f & (!full | popm);
        chk("sb_stall", {31'b0, stall_o}, {31'b0, full & !popm});
        chk("sb_outstanding", {29'b0, outstanding_o}, sz);
        chk("sb_valid_o", {30'b0, rsp_valid_o}, {30'b0, vexp});
        chk("sb_ready_o", {31'b0, rsp_ready_o}, {31'b0, rexp});
        chk("sb_err", {31'b0, err_o}, {31'b0, err_m});
        if (popm) begin
            chk("sb_data", rsp_data_o, rd);
            void'(exp_q.pop_front());
        end
        if ((f & full & !popm) | (rv & empty)) err_m = 1'b1;
        if (pushm) exp_q.push_back(s);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    endtask

    task automatic do_reset(input logic rv);
        @(negedge clk_i);
        req_fire_i = 1'b0; rsp_valid_i = rv; rsp_ready_i = 2'b11;
        reset_i = 1'b1;
        #1;
        chk("rst_outstanding", {29'b0, outstanding_o}, 0);
        chk("rst_err", {31'b0, err_o}, 0);
        chk("rst_stall", {31'b0, stall_o}, 0);
        chk("rst_valid_o", {30'b0, rsp_valid_o}, 0);
        chk("rst_ready_o", {31'b0, rsp_ready_o}, 0);
        exp_q.delete();
        err_m = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0; rsp_valid_i = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1, 1, 0, 32'h00, 2'b00, 0, 0, 2'b00, 0, 0};
        tbl[1]  = '{1, 0, 0, 32'h00, 2'b00, 0, 1, 2'b00, 0, 0};
        tbl[2]  = '{0, 0, 1, 32'hA5, 2'b11, 0, 2, 2'b10, 1, 0};
        tbl[3]  = '{0, 0, 1, 32'h5A, 2'b11, 0, 1, 2'b01, 1, 0};
        tbl[4]  = '{0, 0, 0, 32'h00, 2'b00, 0, 0, 2'b00, 0, 0};
        tbl[5]  = '{1, 0, 0, 32'h00, 2'b00, 0, 0, 2'b00, 0, 0};
        tbl[6]  = '{0, 0, 1, 32'h33, 2'b10, 0, 1, 2'b01, 0, 0};
        tbl[7]  = '{0, 0, 1, 32'h33, 2'b10, 0, 1, 2'b01, 0, 0};
        tbl[8]  = '{0, 0, 1, 32'h33, 2'b10, 0, 1, 2'b01, 0, 0};
        tbl[9]  = '{0, 0, 1, 32'h33, 2'b01, 0, 1, 2'b01, 1, 0};
        tbl[10] = '{0, 0, 0, 32'h00, 2'b00, 0, 0, 2'b00, 0, 0};

        do_reset(1'b0);
        idle();

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].f, tbl[i].s, tbl[i].rv, tbl[i].rd, tbl[i].rr);
            chk($sformatf("vec%0d_stall", i), {31'b0, stall_o}, {31'b0, tbl[i].e_stall});
            chk($sformatf("vec%0d_out", i), {29'b0, outstanding_o}, {29'b0, tbl[i].e_out});
            chk($sformatf("vec%0d_vo", i), {30'b0, rsp_valid_o}, {30'b0, tbl[i].e_vo});
            chk($sformatf("vec%0d_ro", i), {31'b0, rsp_ready_o}, {31'b0, tbl[i].e_ro});
            chk($sformatf("vec%0d_err", i), {31'b0, err_o}, {31'b0, tbl[i].e_err});
            if (tbl[i].rv && tbl[i].e_ro) chk($sformatf("vec%0d_data", i), rsp_data_o, tbl[i].rd);
        end

        for (int i = 0; i < 4; i++) step(1'b1, 1'(i % 2 == 0), 1'b0, 32'h0, 2'b00);
        step(1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        chk("full_stall", {31'b0, stall_o}, 1);
        chk("full_out", {29'b0, outstanding_o}, 4);
        step(1'b1, 1'b1, 1'b1, 32'hC0DE, 2'b11);
        chk("drop_err", {31'b0, err_o}, 1);
        chk("fire_pop_stall", {31'b0, stall_o}, 0);
        chk("fire_pop_vo", {30'b0, rsp_valid_o}, 2'b10);
        idle();
        chk("fire_pop_out", {29'b0, outstanding_o}, 4);
        chk("new_id_last", {31'b0, exp_q[3]}, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h100 + i, 2'b11);
        step(1'b0, 1'b0, 1'b1, 32'h1FF, 2'b11);
        chk("last_vo", {30'b0, rsp_valid_o}, 2'b10);
        idle();

        do_reset(1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'(i % 2), exp_q.size() > 0, $urandom, 2'b11);
        for (int i = 0; i < 8 && exp_q.size() > 0; i++)
            step(1'b0, 1'b0, 1'b1, $urandom, 2'b11);
        idle();
        chk("wrap_err", {31'b0, err_o}, 0);
        chk("wrap_out", {29'b0, outstanding_o}, 0);

        step(1'b0, 1'b0, 1'b1, 32'hBAD, 2'b00);
        chk("spur_ready", {31'b0, rsp_ready_o}, 1);
        idle();
        chk("spur_err", {31'b0, err_o}, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
        idle();
        chk("pre_rst_out", {29'b0, outstanding_o}, 2);
        do_reset(1'b1);
        idle();

        $display("[TB] %0d tests run, %0d failed", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time %0t exceeded bound", $time);
        $fatal(1, "timeout");
    end

endmodule
